hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Generates the freeze/flush controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers.
//  - Detects RAW hazards between the ID-stage sources and the destinations held in ID/EX and EX/MEM.
//  - Applies branch-taken squash and stalls the whole pipe while a memory access waits for SRAM.
//  - Keeps saturating stall/flush performance counters.
// PARAMETERS
//  CNT_W        16    width of the stall_cnt / flush_cnt performance counters
//  TIMEOUT      255   MEM_WAIT cycle count at which mem_timeout is set (8-bit compare, 1..255)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  id_valid      in   1   ID stage holds a real instruction
//  id_src1       in   4   Rn index of the instruction in ID
//  id_src2       in   4   Rm/Rd index of the instruction in ID
//  id_two_src    in   1   id_src2 is read (register operand or store)
//  idex_dest     in   4   Dest output of the ID/EX register
//  idex_wb_en    in   1   WB_EN output of the ID/EX register
//  idex_mem_r_en in   1   MEM_R_EN output of the ID/EX register
//  exmem_dest    in   4   Dest output of the EX/MEM register
//  exmem_wb_en   in   1   WB_EN output of the EX/MEM register
//  br_taken      in   1   branch resolved taken in EXE
//  mem_req       in   1   MEM stage issues an SRAM read/write this cycle
//  mem_ready     in   1   SRAM completes the access this cycle
//  cnt_clr       in   1   synchronous clear of both counters
//  pc_freeze     out  1   hold PC
//  ifid_freeze   out  1   hold IF/ID
//  ifid_flush    out  1   zero IF/ID
//  idex_freeze   out  1   hold ID/EX
//  idex_flush    out  1   zero ID/EX (bubble)
//  exmem_freeze  out  1   hold EX/MEM
//  mem_timeout   out  1   sticky: MEM_WAIT reached TIMEOUT cycles
//  stall_cnt     out  CNT_W  cycles with any freeze asserted, saturating
//  flush_cnt     out  CNT_W  branch squashes applied, saturating
// BEHAVIOUR
//  - FSM: RUN, MEM_WAIT.
//    - RUN -> MEM_WAIT when mem_req & ~mem_ready.
//    - MEM_WAIT -> RUN on the cycle mem_ready=1.
//  - mem_stall = (state==MEM_WAIT & ~mem_ready) | (state==RUN & mem_req & ~mem_ready). Combinational.
//  - mem_stall=1 overrides everything:
//    - pc/ifid/idex/exmem_freeze=1; both flushes=0.
//    - A br_taken seen during the stall is not applied; EXE is frozen, so it is applied once the stall lifts.
//  - Else if br_taken: ifid_flush=1, idex_flush=1, all freezes=0. The hazard result is ignored (the instruction is squashed).
//  - Else if hazard: pc_freeze=1, ifid_freeze=1, idex_flush=1; idex/exmem_freeze=0. This inserts one bubble per cycle until the hazard clears.
//  - Else all control outputs are 0.
//  - match(d) = (id_src1==d) | (id_two_src & id_src2==d). Never asserted when id_valid=0.
//  - While rst=1 all control outputs are forced 0.
//  - wait_cnt (8 bit):
//    - Cleared on entry to MEM_WAIT, then increments each MEM_WAIT cycle.
//    - When it equals TIMEOUT, mem_timeout<=1. mem_timeout is cleared only by rst.
//    - The FSM keeps waiting after timeout.
//  - stall_cnt increments in any cycle with pc_freeze|exmem_freeze.
//  - flush_cnt increments in any cycle with ifid_flush.
//  - Both counters saturate at all-ones. cnt_clr forces them to 0 and wins over increment.
//  - Reset: state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
//  - Reset mid-MEM_WAIT: state returns to RUN immediately. Reset is asynchronous.
//  - Latency: all freeze/flush outputs are combinational in the same cycle as their cause. Only FSM, wait_cnt and counters are registered.
// CONFIGURATION
//  - FORWARDING_EN defined:
//    - hazard = id_valid & idex_wb_en & idex_mem_r_en & match(idex_dest). This is load-use only: exactly one bubble per load-use.
//    - EX/MEM destinations are ignored; the forwarding unit covers them.
//  - FORWARDING_EN undefined:
//    - hazard = id_valid & ((idex_wb_en & match(idex_dest)) | (exmem_wb_en & match(exmem_dest))).
//    - Dependent ALU ops therefore stall up to 2 cycles.
// TESTING
//  - Reset:
//    - Stimulus: rst=1 with mem_req=1, br_taken=1.
//    - Response: all outputs 0. After release: state RUN, counters 0.
//  - Load-use:
//    - Stimulus: idex_dest=3, idex_wb_en=1, idex_mem_r_en=1; id_src1=3, id_valid=1.
//    - Response: pc_freeze=ifid_freeze=idex_flush=1 for exactly 1 cycle; stall_cnt=1.
//  - ALU dependence:
//    - Stimulus: exmem_dest=5, exmem_wb_en=1, id_src2=5, id_two_src=1, mem_r_en=0.
//    - Response: stall only without FORWARDING_EN; no freeze with it.
//  - Branch vs hazard:
//    - Stimulus: br_taken=1 and a load-use hazard in the same cycle.
//    - Response: ifid_flush=idex_flush=1, pc_freeze=0; flush_cnt +1.
//  - Memory wait:
//    - Stimulus: mem_req=1, mem_ready=0 for 4 cycles, then 1; br_taken=1 throughout.
//    - Response: all 4 freezes=1 for 4 cycles, flushes 0; the next cycle applies the branch flush; stall_cnt=4.
//  - Timeout / saturation:
//    - TIMEOUT=3: mem_ready held 0 -> mem_timeout=1 after 3 wait cycles and stays 1.
//    - CNT_W=2: 5 stall cycles -> stall_cnt=3; cnt_clr -> 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose:
//   Generates the freeze/flush controls for the IF/ID, ID/EX and EX/MEM
//   pipeline registers of the in-order core:
//     - RAW hazard detection between the ID-stage source registers and the
//       destinations held in ID/EX and EX/MEM (load-use only when the
//       forwarding unit is present).
//     - Branch-taken squash of the two younger stages.
//     - Whole-pipe freeze while a memory access waits for the SRAM.
//     - Saturating performance counters for stall and flush cycles.
//
// Configuration macro:
//   FORWARDING_EN  defined   : only load-use hazards (ID/EX load) stall.
//                  undefined : any pending write in ID/EX or EX/MEM that
//                              matches an ID source stalls.
//
// Parameters:
//   CNT_W    width of stall_cnt / flush_cnt
//   TIMEOUT  MEM_WAIT cycle count (1..255) at which mem_timeout is set
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   id_valid            ID stage holds a real instruction
//   id_src1, id_src2    source register indices of the ID instruction
//   id_two_src          id_src2 is actually read
//   idex_dest/_wb_en    destination / write-enable held in ID/EX
//   idex_mem_r_en       ID/EX instruction is a load
//   exmem_dest/_wb_en   destination / write-enable held in EX/MEM
//   br_taken            branch resolved taken in EXE
//   mem_req, mem_ready  SRAM request from MEM, SRAM completion
//   cnt_clr             synchronous clear of both counters
//   pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush,
//   exmem_freeze        combinational pipeline controls
//   mem_timeout         sticky flag, MEM_WAIT lasted TIMEOUT cycles
//   stall_cnt           cycles with any freeze, saturating
//   flush_cnt           branch squashes applied, saturating
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       idex_dest,
    input  logic             idex_wb_en,
    input  logic             idex_mem_r_en,
    input  logic [3:0]       exmem_dest,
    input  logic             exmem_wb_en,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             ifid_flush,
    output logic             idex_freeze,
    output logic             idex_flush,
    output logic             exmem_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

    // Source/destination comparison for one candidate destination register.
    function automatic logic src_match(input logic [3:0] d,
                                       input logic [3:0] s1,
                                       input logic [3:0] s2,
                                       input logic       two_src);
        return (s1 == d) | (two_src & (s2 == d));
    endfunction

    // Counter increment that holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // 8-bit wait counter increment; holds at 255 so a very long wait never
    // wraps back through the timeout value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             mem_stall;
    logic             hazard;
    logic [7:0]       wait_inc;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
`ifdef FORWARDING_EN
    // EX/MEM results reach ID through the forwarding paths, so only a load
    // sitting in ID/EX (data not yet available) needs a bubble.
    logic unused_exmem;
    assign unused_exmem = ^{exmem_dest, exmem_wb_en};

    assign hazard = id_valid & idex_wb_en & idex_mem_r_en &
                    src_match(idex_dest, id_src1, id_src2, id_two_src);
`else
    // Without forwarding every in-flight write that a source depends on
    // stalls, regardless of whether it is a load.
    logic unused_mem_r_en;
    assign unused_mem_r_en = idex_mem_r_en;

    assign hazard = id_valid &
                    ((idex_wb_en  & src_match(idex_dest,  id_src1, id_src2, id_two_src)) |
                     (exmem_wb_en & src_match(exmem_dest, id_src1, id_src2, id_two_src)));
`endif

    // The request cycle itself already stalls, so the pipe never advances
    // past an access that has not completed.
    assign mem_stall = ((state_q == ST_MEM_WAIT) & ~mem_ready) |
                       ((state_q == ST_RUN) & mem_req & ~mem_ready);

    // ------------------------------------------------------------------
    // Pipeline controls (combinational, same cycle as their cause)
    // ------------------------------------------------------------------
    always_comb begin
        pc_freeze    = 1'b0;
        ifid_freeze  = 1'b0;
        ifid_flush   = 1'b0;
        idex_freeze  = 1'b0;
        idex_flush   = 1'b0;
        exmem_freeze = 1'b0;
        if (rst) begin
            // all controls stay low while reset is held
        end else if (mem_stall) begin
            // EXE is frozen too, so a pending taken branch is simply held
            // and applied once the memory access completes.
            pc_freeze    = 1'b1;
            ifid_freeze  = 1'b1;
            idex_freeze  = 1'b1;
            exmem_freeze = 1'b1;
        end else if (br_taken) begin
            // The instruction in ID is squashed, so its hazard is moot.
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (hazard) begin
            // Hold IF and ID, push a bubble into EX.
            pc_freeze    = 1'b1;
            ifid_freeze  = 1'b1;
            idex_flush   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM and timeout
    // ------------------------------------------------------------------
    assign wait_inc = sat_inc8(wait_cnt_q);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req & ~mem_ready) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                // The count includes the completing cycle; the flag is set
                // on the edge where the count reaches TIMEOUT.
                wait_cnt_d = wait_inc;
                if (wait_inc == TIMEOUT_V) begin
                    timeout_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (pc_freeze | exmem_freeze) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
            if (ifid_flush) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
